// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit combinational ALU: instruction handshake, operand staging,
// result capture, accumulator writeback. Optional flags enabled by ALU_ISSUE_FLAGS_EN.
module alu_issue_ctrl #(
    parameter logic [7:0]  ACC_INIT = 8'h00,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic             instr_src,
    input  logic [7:0]       instr_imm,
    input  logic [7:0]       instr_b,
    input  logic             instr_wb,
    output logic [7:0]       alu_a0,
    output logic [7:0]       alu_a1,
    output logic             alu_a_sel,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [7:0]       alu_out,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [7:0]       result_data,
    output logic [7:0]       acc,
    output logic [CNT_W-1:0] op_count,
    output logic             flag_z,
    output logic             flag_n
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [7:0]       a0_q, b_q, result_q, acc_q;
    logic [2:0]       ctrl_q;
    logic             a_sel_q, wb_q;
    logic [CNT_W-1:0] count_q;
    logic             accept, capture;

    always_comb begin
        state_d      = state_q;
        instr_ready  = 1'b0;
        result_valid = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;
        case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                capture = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operands stay on the ALU after the operation; they only change on the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0_q    <= 8'h00;
            b_q     <= 8'h00;
            ctrl_q  <= 3'b000;
            a_sel_q <= 1'b0;
            wb_q    <= 1'b0;
        end else if (accept) begin
            a0_q    <= instr_imm;
            b_q     <= instr_b;
            ctrl_q  <= instr_op;
            a_sel_q <= instr_src;
            wb_q    <= instr_wb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 8'h00;
            acc_q    <= ACC_INIT;
            count_q  <= '0;
        end else if (capture) begin
            result_q <= alu_out;
            if (wb_q) begin
                acc_q <= alu_out;
            end
            if (count_q != {CNT_W{1'b1}}) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

`ifdef ALU_ISSUE_FLAGS_EN
    logic flag_z_q, flag_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if (capture) begin
            flag_z_q <= (alu_out == 8'h00);
            flag_n_q <= alu_out[7];
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
`endif

    assign alu_a0      = a0_q;
    assign alu_a1      = acc_q;
    assign alu_a_sel   = a_sel_q;
    assign alu_b       = b_q;
    assign alu_ctrl    = ctrl_q;
    assign result_data = result_q;
    assign acc         = acc_q;
    assign op_count    = count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, table vectors, directed corner
// sequences and randomized instructions against an accumulator/counter reference model.
module tb_alu_issue_ctrl;

    localparam int unsigned CntW   = 4;
    localparam int          CntMax = (1 << CntW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            instr_valid, instr_ready;
    logic [2:0]      instr_op;
    logic            instr_src, instr_wb;
    logic [7:0]      instr_imm, instr_b;
    logic [7:0]      alu_a0, alu_a1, alu_b, alu_out;
    logic            alu_a_sel;
    logic [2:0]      alu_ctrl;
    logic            result_valid, result_ready;
    logic [7:0]      result_data, acc;
    logic [CntW-1:0] op_count;
    logic            flag_z, flag_n;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state
    logic [7:0] m_acc;
    int         m_cnt;
    logic       m_z, m_n;

    alu_issue_ctrl #(
        .ACC_INIT (8'h00),
        .CNT_W    (CntW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_src    (instr_src),
        .instr_imm    (instr_imm),
        .instr_b      (instr_b),
        .instr_wb     (instr_wb),
        .alu_a0       (alu_a0),
        .alu_a1       (alu_a1),
        .alu_a_sel    (alu_a_sel),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_out      (alu_out),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
        .acc          (acc),
        .op_count     (op_count),
        .flag_z       (flag_z),
        .flag_n       (flag_n)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
        case (op)
            3'd0:    alu_f = a + b;
            3'd1:    alu_f = a - b;
            3'd2:    alu_f = a | b;
            3'd3:    alu_f = a & b;
            3'd4:    alu_f = a ^ b;
            3'd5:    alu_f = ~a;
            3'd6:    alu_f = {a[6:0], 1'b0};
            default: alu_f = {1'b0, a[7:1]};
        endcase
    endfunction

    // Stand-in for the external combinational ALU with its A-input mux.
    always_comb alu_out = alu_f(alu_ctrl, alu_a_sel ? alu_a1 : alu_a0, alu_b);

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 8'h00;
        m_cnt = 0;
        m_z   = 1'b0;
        m_n   = 1'b0;
    endtask

    // One full instruction: accept, EXEC, RESP with 'stall' cycles of backpressure.
    task automatic do_instr(input logic [2:0] op, input logic src, input logic [7:0] imm,
                            input logic [7:0] b, input logic wb, input int stall,
                            input logic hold_valid, output logic [7:0] got);
        logic [7:0] a, res;
        @(negedge clk);
        check("ready_idle", 16'(instr_ready), 16'h1);
        check("rvalid_idle", 16'(result_valid), 16'h0);
        instr_op     = op;
        instr_src    = src;
        instr_imm    = imm;
        instr_b      = b;
        instr_wb     = wb;
        instr_valid  = 1'b1;
        result_ready = 1'b0;
        @(posedge clk);
        #1;
        a   = src ? m_acc : imm;
        res = alu_f(op, a, b);
        // Inputs after the accept edge must be ignored.
        instr_op    = 3'($urandom);
        instr_src   = 1'($urandom);
        instr_imm   = 8'($urandom);
        instr_b     = 8'($urandom);
        instr_wb    = 1'($urandom);
        instr_valid = hold_valid;
        @(negedge clk);
        check("ready_exec", 16'(instr_ready), 16'h0);
        check("rvalid_exec", 16'(result_valid), 16'h0);
        check("alu_ctrl", 16'(alu_ctrl), 16'(op));
        check("alu_a0", 16'(alu_a0), 16'(imm));
        check("alu_b", 16'(alu_b), 16'(b));
        check("alu_a_sel", 16'(alu_a_sel), 16'(src));
        check("alu_a1", 16'(alu_a1), 16'(m_acc));
        if (wb) m_acc = res;
        if (m_cnt < CntMax) m_cnt++;
`ifdef ALU_ISSUE_FLAGS_EN
        m_z = (res == 8'h00);
        m_n = res[7];
`endif
        @(negedge clk);
        check("rvalid_resp", 16'(result_valid), 16'h1);
        check("result_data", 16'(result_data), 16'(res));
        check("acc", 16'(acc), 16'(m_acc));
        check("op_count", 16'(op_count), 16'(m_cnt));
        check("flag_z", 16'(flag_z), 16'(m_z));
        check("flag_n", 16'(flag_n), 16'(m_n));
        got = result_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("rvalid_stall", 16'(result_valid), 16'h1);
            check("rdata_stall", 16'(result_data), 16'(res));
            check("ready_stall", 16'(instr_ready), 16'h0);
            check("count_stall", 16'(op_count), 16'(m_cnt));
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        instr_valid  = 1'b0;
    endtask

    typedef struct {
        logic [2:0] op;
        logic       src;
        logic [7:0] imm;
        logic [7:0] b;
        logic       wb;
        logic [7:0] exp_res;
        logic [7:0] exp_acc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [7:0] got;

        tbl[0] = '{3'd0, 1'b0, 8'h7F, 8'h01, 1'b1, 8'h80, 8'h80};  // ADD
        tbl[1] = '{3'd1, 1'b0, 8'h00, 8'h01, 1'b1, 8'hFF, 8'hFF};  // SUB wraps
        tbl[2] = '{3'd4, 1'b1, 8'h3C, 8'hFF, 1'b1, 8'h00, 8'h00};  // XOR with acc
        tbl[3] = '{3'd2, 1'b0, 8'h81, 8'h00, 1'b1, 8'h81, 8'h81};  // OR
        tbl[4] = '{3'd7, 1'b1, 8'h00, 8'h00, 1'b1, 8'h40, 8'h40};  // LSR acc
        tbl[5] = '{3'd6, 1'b1, 8'h00, 8'h00, 1'b1, 8'h80, 8'h80};  // LSL acc
        tbl[6] = '{3'd5, 1'b1, 8'h00, 8'h00, 1'b0, 8'h7F, 8'h80};  // NOT, no wb
        tbl[7] = '{3'd3, 1'b0, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h80};  // AND, no wb

        rst_n        = 1'b0;
        instr_valid  = 1'b0;
        instr_op     = 3'd0;
        instr_src    = 1'b0;
        instr_imm    = 8'h00;
        instr_b      = 8'h00;
        instr_wb     = 1'b0;
        result_ready = 1'b0;
        model_reset();
        #12;
        check("rst_ready", 16'(instr_ready), 16'h1);
        check("rst_rvalid", 16'(result_valid), 16'h0);
        check("rst_acc", 16'(acc), 16'h00);
        check("rst_count", 16'(op_count), 16'h0);
        check("rst_ctrl", 16'(alu_ctrl), 16'h0);
        check("rst_flags", {14'h0, flag_z, flag_n}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-EXEC discards the pending writeback.
        @(negedge clk);
        instr_op    = 3'd0;
        instr_src   = 1'b0;
        instr_imm   = 8'h55;
        instr_b     = 8'h11;
        instr_wb    = 1'b1;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        check("mid_ready_exec", 16'(instr_ready), 16'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 16'(instr_ready), 16'h1);
        check("mid_rst_acc", 16'(acc), 16'h00);
        check("mid_rst_count", 16'(op_count), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_post_rvalid", 16'(result_valid), 16'h0);
        check("mid_post_acc", 16'(acc), 16'h00);
        check("mid_post_count", 16'(op_count), 16'h0);
        model_reset();

        for (int i = 0; i < 8; i++) begin
            do_instr(tbl[i].op, tbl[i].src, tbl[i].imm, tbl[i].b, tbl[i].wb, 0, 1'b0, got);
            check($sformatf("tbl%0d_res", i), 16'(got), 16'(tbl[i].exp_res));
            check($sformatf("tbl%0d_acc", i), 16'(acc), 16'(tbl[i].exp_acc));
        end

        // Backpressure with a new instruction held on the input.
        do_instr(3'd0, 1'b1, 8'h00, 8'h05, 1'b1, 5, 1'b1, got);
        check("bp_res", 16'(got), 16'h85);
        do_instr(3'd1, 1'b1, 8'h00, 8'h05, 1'b0, 0, 1'b0, got);
        check("bp_second_res", 16'(got), 16'h80);

        for (int i = 0; i < 6; i++) begin
            do_instr(3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                     0, 1'b0, got);
        end
        check("count_saturated", 16'(op_count), 16'h000F);

        for (int i = 0; i < 150; i++) begin
            do_instr(3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                     int'($urandom_range(0, 3)), 1'($urandom), got);
        end
        check("count_final", 16'(op_count), 16'h000F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential initiator for the 8-bit combinational ALU (ops ADD/SUB/OR/AND/XOR/NOT/LSL/LSR, 3-bit ctrl, 2:1 A-input mux).
- Accepts one instruction per valid/ready handshake and drives registered operands and ctrl into the ALU.
- Samples the ALU result one cycle later and presents it on a valid/ready result port.
- Optionally writes the result back to an internal accumulator, which feeds the ALU's a1 input.

Parameters:
ACC_INIT, 8'h00, accumulator reset value.
CNT_W, 16, width of completed-operation counter.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept instruction
instr_op  in  3  ALU opcode (000 ADD … 111 LSR)
instr_src  in  1  0: A operand = instr_imm; 1: A operand = accumulator
instr_imm  in  8  immediate A operand
instr_b  in  8  B operand
instr_wb  in  1  write result into accumulator
alu_a0  out  8  to ALU a0_mux (registered imm)
alu_a1  out  8  to ALU a1_mux (accumulator)
alu_a_sel  out  1  to ALU a_sel (registered instr_src)
alu_b  out  8  to ALU b
alu_ctrl  out  3  to ALU ctrl
alu_out  in  8  from ALU out
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_data  out  8  captured result
acc  out  8  accumulator value
op_count  out  CNT_W  completed-operation count
flag_z  out  1  result zero (see Optional Feature)
flag_n  out  1  result bit 7 (see Optional Feature)

Behaviour:
Reset (rst_n low, async):
- state=IDLE; acc=ACC_INIT.
- alu_a0, alu_b, alu_ctrl, alu_a_sel, result_data, op_count, flags = 0; result_valid=0.
- Takes effect immediately, including mid-operation. Any in-flight instruction is discarded without writeback.

FSM states:
- IDLE: instr_ready=1. On instr_valid&instr_ready, register imm→alu_a0, b→alu_b, op→alu_ctrl, src→alu_a_sel and wb (internal). Go to EXEC.
- EXEC: instr_ready=0. ALU inputs are stable for this full cycle. At the cycle-end edge:
  - result_data←alu_out.
  - If wb: acc←alu_out.
  - op_count←op_count+1, saturating at all-ones (no wrap).
  - Go to RESP.
- RESP: result_valid=1 and result_data held stable. On result_ready, go to IDLE; result_valid drops the next cycle.
- Illegal/unused encodings go to IDLE.

Timing and data rules:
- alu_a1 = acc continuously, so ALU sees the accumulator from the previous writeback.
- alu_* outputs hold their last values outside EXEC and are not cleared on return to IDLE.
- Latency: accept edge T0 → result_valid high after T1 (two edges). Minimum 3 cycles per instruction with result_ready tied high.
- No overlap: instr_ready=0 in EXEC/RESP, so an instr_valid held high there is not consumed.
- instr_* must be sampled only at the accept edge; later changes are ignored.
- result_ready outside RESP is ignored.
- All arithmetic is 8-bit modulo 2^8; carry/borrow are not observed.

Optional Feature:
Macro ALU_ISSUE_FLAGS_EN.
- Defined: flag_z/flag_n are registered at the EXEC capture edge (flag_z = alu_out==0, flag_n = alu_out[7]) and held until the next capture.
- Undefined: flag_z and flag_n tied 0 and no flag registers are synthesized. Ports always exist.

Test Plan:
- Reset → instr_ready=1, result_valid=0, acc=8'h00, op_count=0; assert rst_n low mid-EXEC → state IDLE, acc unchanged from pre-instruction value, op_count not incremented.
- ADD src=0 imm=8'h7F b=8'h01 wb=1, result_ready=1 → result_data=8'h80 two edges after accept, acc=8'h80, flag_n=1 (flags enabled).
- SUB src=0 imm=8'h00 b=8'h01 → result_data=8'hFF (wrap); then XOR src=1 b=8'hFF with acc=8'hFF after wb → result 8'h00, flag_z=1.
- Chain: acc=8'h81, LSR src=1 wb=1 → 8'h40; LSL src=1 wb=1 → 8'h80; NOT src=1 → 8'h7F, acc stays 8'h80 (wb=0).
- Backpressure: result_ready=0 for 5 cycles in RESP with instr_valid held high → result_data stable, instr_ready=0, second instruction accepted only after the result handshake.
- op_count preloaded near saturation (CNT_W=4 build, 16 ops) → op_count sticks at 4'hF.
